// File: rtl/kw_match_multi.sv
// kw_match_multi: groups a received byte stream into words and reports which
// of NUM_KW programmable keywords the whole word equals.
// A word closes on a TERM byte (when a word is open) or after TIMEOUT idle
// cycles. The result appears one cycle after the closing edge.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   data_valid    one-cycle strobe qualifying data_in
//   data_in       received byte
//   busy          a word is open
//   result_valid  one-cycle pulse: a word closed
//   result_hit    closed word equals a keyword (valid with result_valid)
//   result_id     1-based keyword index on hit, else 0
//   result_ascii  8'h30 + result_id, held until the next close

// Per-keyword compare lane: advances the alive flag on an accepted byte and
// evaluates the hit condition for a close.
module kw_match_lane #(
  parameter int MAX_LEN = 8
) (
  input  logic               alive,
  input  logic [3:0]         pos,
  input  logic               ovf,
  input  logic [7:0]         din_f,
  input  logic [MAX_LEN*8-1:0] kw_str,
  input  logic [3:0]         kw_len,
  output logic               alive_nxt,
  output logic               hit
);
  logic [7:0] ch;

  // pos may equal MAX_LEN (saturated); the mux then yields 0, and the
  // pos < kw_len term already kills the lane.
  always_comb begin
    ch = '0;
    for (int j = 0; j < MAX_LEN; j++)
      if (pos == 4'(j)) ch = kw_str[j*8 +: 8];
  end

  assign alive_nxt = alive & (pos < kw_len) & (din_f == ch);
  assign hit       = alive & (pos == kw_len) & ~ovf;
endmodule

module kw_match_multi #(
  parameter int NUM_KW   = 3,
  parameter int MAX_LEN  = 8,
  // keyword i, char j at [(i*MAX_LEN+j)*8 +: 8]: "start", "stop", "hitsz"
  parameter logic [NUM_KW*MAX_LEN*8-1:0] KW_STR = {
    64'h0000_007a_7374_6968,
    64'h0000_0000_706f_7473,
    64'h0000_0074_7261_7473},
  parameter logic [NUM_KW*4-1:0] KW_LEN = 12'h545,
  parameter logic [7:0] TERM     = 8'h0A,
  parameter int         TIMEOUT  = 104260,
  parameter bit         CASE_INS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       result_valid,
  output logic       result_hit,
  output logic [3:0] result_id,
  output logic [7:0] result_ascii
);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TMO_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [NUM_KW-1:0] alive, alive_nxt, hit;
  logic [3:0]        pos;
  logic              ovf;
  logic [IW-1:0]     idle_cnt;
  logic [7:0]        din_f;
  logic [3:0]        hit_id;
  logic              accept, term, tmo, close;

  always_comb begin
    din_f = data_in;
    if (CASE_INS && data_in >= 8'h41 && data_in <= 8'h5A)
      din_f = data_in | 8'h20;
  end

  for (genvar i = 0; i < NUM_KW; i++) begin : g_lane
    kw_match_lane #(.MAX_LEN(MAX_LEN)) u_lane (
      .alive     (alive[i]),
      .pos       (pos),
      .ovf       (ovf),
      .din_f     (din_f),
      .kw_str    (KW_STR[i*MAX_LEN*8 +: MAX_LEN*8]),
      .kw_len    (KW_LEN[i*4 +: 4]),
      .alive_nxt (alive_nxt[i]),
      .hit       (hit[i])
    );
  end

  // lowest index wins: scan downwards so the last assignment is the lowest hit
  always_comb begin
    hit_id = '0;
    for (int i = NUM_KW - 1; i >= 0; i--)
      if (hit[i]) hit_id = 4'(i + 1);
  end

  assign accept = data_valid && (data_in != TERM);
  assign term   = data_valid && (data_in == TERM) && busy;
  // idle_cnt is 0 after the last byte, so it reads TIMEOUT-1 at edge E(TIMEOUT)
  assign tmo    = (TIMEOUT != 0) && busy && !data_valid && (idle_cnt == TMO_LAST);
  assign close  = term || tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      pos          <= '0;
      ovf          <= 1'b0;
      alive        <= '1;
      idle_cnt     <= '0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      result_id    <= '0;
      result_ascii <= 8'h30;
    end else begin
      result_valid <= close;
      result_hit   <= close && (|hit);
      result_id    <= close ? hit_id : 4'd0;
      if (close) result_ascii <= 8'h30 + {4'h0, hit_id};

      if (close) begin
        busy     <= 1'b0;
        pos      <= '0;
        ovf      <= 1'b0;
        alive    <= '1;
        idle_cnt <= '0;
      end else if (accept) begin
        busy     <= 1'b1;
        idle_cnt <= '0;
        alive    <= alive_nxt;
        if (pos == 4'(MAX_LEN)) ovf <= 1'b1;
        else                    pos <= pos + 4'd1;
      end else if (busy && !data_valid) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_kw_match_multi.sv
// Bench for kw_match_multi: three instances share one stimulus stream
// (case-sensitive default keywords, case-insensitive, duplicate keywords).
// A string-level word model predicts every output after every clock edge.
module tb_kw_match_multi;
  localparam int TMO = 16;
  localparam logic [7:0] TERM = 8'h0A;

  logic clk, rst, data_valid;
  logic [7:0] data_in;
  logic       busy_o [3];
  logic       rv     [3];
  logic       rh     [3];
  logic [3:0] rid    [3];
  logic [7:0] ra     [3];

  int errors = 0;
  int checks = 0;

  kw_match_multi #(.TIMEOUT(TMO), .CASE_INS(1'b0)) u0 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .busy(busy_o[0]), .result_valid(rv[0]), .result_hit(rh[0]),
    .result_id(rid[0]), .result_ascii(ra[0]));

  kw_match_multi #(.TIMEOUT(TMO), .CASE_INS(1'b1)) u1 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .busy(busy_o[1]), .result_valid(rv[1]), .result_hit(rh[1]),
    .result_id(rid[1]), .result_ascii(ra[1]));

  // keywords: 0 "stop", 1 "start", 2 "stop"
  kw_match_multi #(
    .TIMEOUT(TMO), .CASE_INS(1'b0),
    .KW_STR({64'h0000_0000_706f_7473, 64'h0000_0074_7261_7473, 64'h0000_0000_706f_7473}),
    .KW_LEN(12'h454)
  ) u2 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .busy(busy_o[2]), .result_valid(rv[2]), .result_hit(rh[2]),
    .result_id(rid[2]), .result_ascii(ra[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  string      kws [3][3] = '{'{"start", "stop", "hitsz"},
                             '{"start", "stop", "hitsz"},
                             '{"stop", "start", "stop"}};
  bit         cins [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] wbuf [3][64];
  int         wlen [3];
  int         idle [3];
  logic       ev [3], eh [3];
  logic [3:0] eid [3];
  logic [7:0] ea [3];

  function automatic logic [7:0] fold(input int c, input logic [7:0] b);
    if (cins[c] && b >= "A" && b <= "Z") return b + 8'd32;
    return b;
  endfunction

  function automatic int match_id(input int c);
    for (int i = 0; i < 3; i++) begin
      string s = kws[c][i];
      if (wlen[c] == s.len()) begin
        bit eq = 1'b1;
        for (int j = 0; j < s.len(); j++)
          if (wbuf[c][j] != s[j]) eq = 1'b0;
        if (eq) return i + 1;
      end
    end
    return 0;
  endfunction

  task automatic model(input bit r, input bit dv, input logic [7:0] b);
    for (int c = 0; c < 3; c++) begin
      bit cl = 1'b0;
      if (r) begin
        wlen[c] = 0; idle[c] = 0;
        ev[c] = 0; eh[c] = 0; eid[c] = 0; ea[c] = 8'h30;
      end else begin
        if (dv && b != TERM) begin
          if (wlen[c] < 64) wbuf[c][wlen[c]] = fold(c, b);
          wlen[c]++;
          idle[c] = 0;
        end else if (dv) begin
          if (wlen[c] > 0) cl = 1'b1;
        end else if (wlen[c] > 0) begin
          idle[c]++;
          if (idle[c] == TMO) cl = 1'b1;
        end
        if (cl) begin
          int id = match_id(c);
          ev[c] = 1; eh[c] = (id != 0); eid[c] = 4'(id); ea[c] = 8'h30 + 8'(id);
          wlen[c] = 0; idle[c] = 0;
        end else begin
          ev[c] = 0; eh[c] = 0; eid[c] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit dv, input logic [7:0] b);
    @(negedge clk);
    rst = r; data_valid = dv; data_in = b;
    @(posedge clk);
    model(r, dv, b);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("u%0d busy", c),  {7'd0, busy_o[c]}, {7'd0, wlen[c] > 0});
      chk($sformatf("u%0d valid", c), {7'd0, rv[c]},     {7'd0, ev[c]});
      chk($sformatf("u%0d hit", c),   {7'd0, rh[c]},     {7'd0, eh[c]});
      chk($sformatf("u%0d id", c),    {4'd0, rid[c]},    {4'd0, eid[c]});
      chk($sformatf("u%0d ascii", c), ra[c],             ea[c]);
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i]);
  endtask
  task automatic term();
    step(1'b0, 1'b1, TERM);
  endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  string pool [10] = '{"start", "stop", "hitsz", "STOP", "HitSz",
                       "stopx", "xstop", "st", "sta rt", "stopstop"};

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = 8'h00;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("reset ascii", ra[0], 8'h30);
    chk("reset busy", {7'd0, busy_o[0]}, 8'd0);

    // "stop" + TERM: hit id 2 the cycle after TERM
    send("stop"); term();
    chk("stop valid", {7'd0, rv[0]}, 8'd1);
    chk("stop id", {4'd0, rid[0]}, 8'd2);
    chk("stop ascii", ra[0], 8'h32);
    chk("dup stop id", {4'd0, rid[2]}, 8'd1);
    idle_n(2);
    chk("ascii hold", ra[0], 8'h32);

    // timeout close exactly TMO edges after the last byte
    send("hitsz"); idle_n(TMO - 1);
    chk("tmo early", {7'd0, rv[0]}, 8'd0);
    idle_n(1);
    chk("tmo valid", {7'd0, rv[0]}, 8'd1);
    chk("tmo id", {4'd0, rid[0]}, 8'd3);
    chk("tmo ascii", ra[0], 8'h33);

    // byte on the would-be timeout edge extends the word
    send("hitsz"); idle_n(TMO - 1); send("x");
    chk("ext no valid", {7'd0, rv[0]}, 8'd0);
    idle_n(TMO);
    chk("ext valid", {7'd0, rv[0]}, 8'd1);
    chk("ext id", {4'd0, rid[0]}, 8'd0);
    chk("ext ascii", ra[0], 8'h30);

    // back-to-back words, bare terminator
    send("sta"); term(); send("start"); term();
    chk("b2b id", {4'd0, rid[0]}, 8'd1);
    term();
    chk("bare term", {7'd0, rv[0]}, 8'd0);

    // overflow and case folding
    send("abcdefghij"); term();
    chk("ovf hit", {7'd0, rh[0]}, 8'd0);
    send("STOP"); term();
    chk("ci id", {4'd0, rid[1]}, 8'd2);
    chk("cs id", {4'd0, rid[0]}, 8'd0);

    // reset mid-word
    send("sto"); step(1'b1, 1'b0, 8'h00);
    chk("rst busy", {7'd0, busy_o[0]}, 8'd0);
    chk("rst ascii", ra[0], 8'h30);
    idle_n(TMO + 2);
    send("stop"); term();
    chk("post rst id", {4'd0, rid[0]}, 8'd2);

    // randomized words with gaps, stray bytes and both close causes
    for (int w = 0; w < 60; w++) begin
      string s = pool[$urandom_range(0, 9)];
      for (int i = 0; i < s.len(); i++) begin
        step(1'b0, 1'b1, s[i]);
        idle_n($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 1) == 1) term();
      else idle_n($urandom_range(TMO - 2, TMO + 4));
      if ($urandom_range(0, 7) == 0) term();
    end
    idle_n(TMO + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
